digit_loader: RTL and testbench
===============================

# digit_loader

Front-panel entry block for the DE-board digit path. It debounces two active-low pushbuttons and shifts the 4-bit value on SW[3:0] into a four-digit register, one digit per ENTER press. The digits are shown on HEX0..HEX3, with undefined positions blanked. The completed 16-bit word is presented on DIGITS for the downstream digit-rolling logic.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronized key level must hold before it is accepted (10 ms at 50 MHz); legal range ≥ 2.
- CLOCK_50  in  1  system clock, 50 MHz; all state on rising edge.
- RESET_N  in  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset.
- SW  in  4  digit value to enter (0x0–0xF); sampled only on an accepted ENTER event.
- KEY_ENTER_N  in  1  ENTER pushbutton, raw, active-low, asynchronous to CLOCK_50.
- KEY_CLEAR_N  in  1  CLEAR pushbutton, raw, active-low, asynchronous to CLOCK_50.
- HEX0..HEX3  out  7 each  seven-segment drive, active-low, bit 0 = segment a … bit 6 = segment g; HEX0 = newest digit.
- DIGITS  out  16  {d3,d2,d1,d0}; d0 = newest digit, in DIGITS[3:0].
- FULL  out  1  high while four digits are held.
- DONE  out  1  one-cycle pulse on the cycle the count becomes 4.

## Operation
- Each key passes through a 2-flop synchronizer, then a debouncer. Stable level resets to 1 (released).
- Debouncer:
  - Counter clears whenever the synchronized level equals the stable level.
  - Otherwise the counter increments each cycle.
  - At count DEBOUNCE_CYCLES-1 the stable level takes the synchronized value and the counter clears.
- Press event = stable level falls 1→0. Only one event per press; release generates nothing.
- ENTER event, count < 4:
  - d3←d2, d2←d1, d1←d0, d0←SW.
  - count increments.
- ENTER event, count = 4: ignored; digits, count and FULL unchanged; no DONE.
- CLEAR event: all digits ← 0, count ← 0, FULL ← 0.
- CLEAR and ENTER events in the same cycle: CLEAR wins; SW is discarded.
- DONE = 1 only on the cycle after the ENTER that makes count go 3→4.
- HEX display:
  - HEXi shows the hex glyph of di when i < count; otherwise it is blank (7'h7F).
  - HEX outputs are combinational from registered digits/count, so they are glitch-free relative to the clock.
- SW values A–F are legal and display as A, b, C, d, E, F.
- Reset mid-debounce discards the pending press; a key still held at reset release must first be seen released before it can generate an event.

## Timing
- Reset values:
  - DIGITS = 0, count = 0, FULL = 0, DONE = 0.
  - HEX0..HEX3 = 7'h7F.
  - Synchronizers = 1, stable levels = 1, debounce counters = 0.
- Latency: if KEY_ENTER_N is first sampled low at edge 0 and held, DIGITS/HEX/FULL update at edge DEBOUNCE_CYCLES+3.
- DONE is high for exactly that one cycle.
- A key glitch shorter than DEBOUNCE_CYCLES cycles after synchronization produces no event.
- Minimum press-to-press spacing accepted: 2×DEBOUNCE_CYCLES cycles (press and release must each be debounced).
- Counter width: clog2(DEBOUNCE_CYCLES); the counter never exceeds DEBOUNCE_CYCLES-1.
- count is 3 bits, saturating at 4.

## Structure
- Shared package (digit_pkg):
  - seven-segment glyph table for 0–F (active-low).
  - SEG_BLANK = 7'h7F.
  - 4-bit digit type.
  - hex-to-segment function, also reused by the rolling display path.
- Sub-module: key_debounce, containing the synchronizer, debounce counter, stable level and falling-edge event output. It is parameterized by DEBOUNCE_CYCLES and instantiated twice (ENTER, CLEAR).
- Top contains the digit shift register, count, DONE logic and HEX muxing.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset: RESET_N low mid-simulation, asynchronously → DIGITS = 0, FULL = 0, DONE = 0, HEX0..3 = 7'h7F immediately, without waiting for a clock edge.
- Enter sequence: SW = 1, 2, 3, 4, each with a clean press held 8 cycles → DIGITS = 16'h1234, FULL = 1, HEX3..HEX0 show 1, 2, 3, 4, single DONE pulse at edge 7 of the fourth press.
- Overflow: fifth ENTER with SW = 9 → DIGITS stays 16'h1234, no DONE.
- Bounce: ENTER toggling low/high every 2 cycles for 20 cycles, then low held 8 cycles → exactly one digit entered.
- Glitch rejection: ENTER low for 3 cycles only → no change.
- Clear/simultaneous: with 16'h1234 held, assert CLEAR and ENTER on the same edge for 8 cycles → DIGITS = 0, count = 0, HEX all 7'h7F, no DONE.
- Partial display: enter SW = 0xA only → HEX0 = glyph A, HEX1..3 = 7'h7F, DIGITS = 16'h000A.

Source files
------------

// File: rtl/digit_pkg.sv
// rtl/digit_pkg.sv - shared digit types and active-low seven-segment glyphs
package digit_pkg;

  typedef logic [3:0] digit_t;

  localparam int DIGIT_COUNT = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index 0 is the rightmost entry; bit 0 = segment a, bit 6 = segment g, active-low.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg(digit_t d);
    return SEG_GLYPH[d];
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronizer, debouncer and press-event pulse for one active-low key
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [1:0]    fill;
  logic          armed;
  logic [CW-1:0] cnt;
  logic          stable;
  logic          stable_d;
  logic          press_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // A key held through reset must be observed released (with real samples) before it may fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      fill <= {fill[0], 1'b1};
      if (fill[1] && sync2 && stable)
        armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b1;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d <= 1'b1;
      press_q  <= 1'b0;
    end else begin
      stable_d <= stable;
      press_q  <= stable_d & ~stable & armed;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/digit_loader.sv
// rtl/digit_loader.sv - front-panel four-digit entry with debounced ENTER/CLEAR and HEX display
module digit_loader
  import digit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [3:0]  SW,
  input  logic        KEY_ENTER_N,
  input  logic        KEY_CLEAR_N,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [15:0] DIGITS,
  output logic        FULL,
  output logic        DONE
);

  logic                             enter_evt;
  logic                             clear_evt;
  logic [DIGIT_COUNT-1:0][3:0]      digits_q;
  logic [2:0]                       count;
  logic                             done_q;
  logic [6:0]                       hex [DIGIT_COUNT];

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .key_n (KEY_ENTER_N),
    .press (enter_evt)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .key_n (KEY_CLEAR_N),
    .press (clear_evt)
  );

  // CLEAR has priority; an ENTER in the same cycle is dropped along with its SW value.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      digits_q <= '0;
      count    <= 3'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear_evt) begin
        digits_q <= '0;
        count    <= 3'd0;
      end else if (enter_evt && count < 3'd4) begin
        digits_q <= {digits_q[2:0], SW};
        count    <= count + 3'd1;
        done_q   <= (count == 3'd3);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DIGIT_COUNT; i++) begin
      hex[i] = (3'(i) < count) ? hex_to_seg(digits_q[i]) : SEG_BLANK;
    end
  end

  assign HEX0   = hex[0];
  assign HEX1   = hex[1];
  assign HEX2   = hex[2];
  assign HEX3   = hex[3];
  assign DIGITS = digits_q;
  assign FULL   = (count == 3'd4);
  assign DONE   = done_q;

endmodule

// File: tb/tb_digit_loader.sv
// tb/tb_digit_loader.sv - randomized self-checking bench for digit_loader against a digit-queue model
module tb_digit_loader;

  localparam int N = 4;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N = 1'b0;
  logic [3:0]  SW = 4'h0;
  logic        KEY_ENTER_N = 1'b1;
  logic        KEY_CLEAR_N = 1'b1;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;
  logic [15:0] DIGITS;
  logic        FULL;
  logic        DONE;

  digit_loader #(.DEBOUNCE_CYCLES(N)) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .SW          (SW),
    .KEY_ENTER_N (KEY_ENTER_N),
    .KEY_CLEAR_N (KEY_CLEAR_N),
    .HEX0        (HEX0),
    .HEX1        (HEX1),
    .HEX2        (HEX2),
    .HEX3        (HEX3),
    .DIGITS      (DIGITS),
    .FULL        (FULL),
    .DONE        (DONE)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: the list of entered digits, newest first, at most four.
  logic [3:0] m [4];
  int         mcount = 0;

  logic [6:0] hex [4];
  assign hex[0] = HEX0;
  assign hex[1] = HEX1;
  assign hex[2] = HEX2;
  assign hex[3] = HEX3;

  always @(negedge CLOCK_50) if (DONE === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  function automatic int model_enter(input logic [3:0] v);
    if (mcount >= 4) return 0;
    m[3] = m[2]; m[2] = m[1]; m[1] = m[0]; m[0] = v;
    mcount++;
    return (mcount == 4) ? 1 : 0;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) m[i] = 4'h0;
    mcount = 0;
  endfunction

  task automatic check_state(input string tag);
    logic [15:0] exp_digits;
    exp_digits = {m[3], m[2], m[1], m[0]};
    check({tag, ".digits"}, 32'(DIGITS), 32'(exp_digits));
    check({tag, ".full"}, 32'(FULL), 32'(mcount == 4));
    for (int i = 0; i < 4; i++)
      check($sformatf("%s.hex%0d", tag, i), 32'(hex[i]),
            32'((i < mcount) ? glyph[m[i]] : 7'h7F));
  endtask

  task automatic release_keys();
    KEY_ENTER_N = 1'b1;
    KEY_CLEAR_N = 1'b1;
    cycles(12);
  endtask

  // Clean ENTER held 8 cycles; measures update edge and DONE edge relative to first sampling edge.
  task automatic enter_timed(input logic [3:0] v, input bit expect_done);
    logic [15:0] prev;
    int lat, done_edge, d0;
    prev = DIGITS; lat = -1; done_edge = -1; d0 = done_cnt;
    SW = v;
    KEY_ENTER_N = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLOCK_50); #1;
      if (lat < 0 && DIGITS !== prev) lat = i;
      if (DONE === 1'b1) done_edge = i;
    end
    void'(model_enter(v));
    release_keys();
    check($sformatf("lat_%0h", v), 32'(lat), 32'(N + 3));
    check($sformatf("done_edge_%0h", v), 32'(done_edge), expect_done ? 32'(N + 3) : 32'hFFFF_FFFF);
    check($sformatf("done_cnt_%0h", v), 32'(done_cnt - d0), 32'(expect_done));
  endtask

  initial begin
    int d0, kind, hold, dn;
    logic [3:0] v;

    model_clear();
    #3;
    check("reset.digits", 32'(DIGITS), 32'h0);
    check("reset.hex3", 32'(HEX3), 32'h7F);
    @(posedge CLOCK_50); #1;
    RESET_N = 1'b1;
    cycles(6);
    check_state("reset");

    d0 = done_cnt;
    enter_timed(4'h1, 1'b0);
    enter_timed(4'h2, 1'b0);
    enter_timed(4'h3, 1'b0);
    enter_timed(4'h4, 1'b1);
    check("seq.digits1234", 32'(DIGITS), 32'h1234);
    check("seq.done_total", 32'(done_cnt - d0), 32'd1);
    check_state("seq");

    d0 = done_cnt;
    SW = 4'h9; KEY_ENTER_N = 1'b0; cycles(8);
    void'(model_enter(4'h9));
    release_keys();
    check("overflow.digits", 32'(DIGITS), 32'h1234);
    check("overflow.done", 32'(done_cnt - d0), 32'd0);
    check_state("overflow");

    d0 = done_cnt;
    SW = 4'h7; KEY_ENTER_N = 1'b0; KEY_CLEAR_N = 1'b0; cycles(8);
    model_clear();
    release_keys();
    check("both.done", 32'(done_cnt - d0), 32'd0);
    check_state("both");

    SW = 4'hA; KEY_ENTER_N = 1'b0; cycles(8);
    void'(model_enter(4'hA));
    release_keys();
    check("partial.hex0", 32'(HEX0), 32'h08);
    check_state("partial");

    SW = 4'h5; KEY_ENTER_N = 1'b0; cycles(3);
    release_keys();
    check_state("glitch");

    SW = 4'h6;
    for (int k = 0; k < 5; k++) begin
      KEY_ENTER_N = 1'b0; cycles(2);
      KEY_ENTER_N = 1'b1; cycles(2);
    end
    KEY_ENTER_N = 1'b0; cycles(8);
    void'(model_enter(4'h6));
    release_keys();
    check_state("bounce");

    // Asynchronous reset mid-cycle with ENTER still held through release.
    KEY_ENTER_N = 1'b0;
    cycles(1);
    #2 RESET_N = 1'b0;
    #1;
    model_clear();
    check("async.digits", 32'(DIGITS), 32'h0);
    check("async.full", 32'(FULL), 32'h0);
    check("async.done", 32'(DONE), 32'h0);
    check("async.hex", 32'({HEX3, HEX2, HEX1, HEX0}), 32'h0FFF_FFFF);
    cycles(1);
    RESET_N = 1'b1;
    cycles(20);
    release_keys();
    check_state("held_at_reset");

    for (int ep = 0; ep < 30; ep++) begin
      kind = $urandom_range(0, 4);
      v = 4'($urandom_range(0, 15));
      SW = v;
      d0 = done_cnt;
      dn = 0;
      case (kind)
        0: begin
          hold = $urandom_range(N + 4, 12);
          KEY_ENTER_N = 1'b0; cycles(hold);
          dn = model_enter(v);
        end
        1: begin
          hold = $urandom_range(1, N - 1);
          KEY_ENTER_N = 1'b0; cycles(hold);
        end
        2: begin
          for (int k = 0; k < 3; k++) begin
            KEY_ENTER_N = 1'b0; cycles($urandom_range(1, 2));
            KEY_ENTER_N = 1'b1; cycles($urandom_range(1, 2));
          end
          KEY_ENTER_N = 1'b0; cycles(8);
          dn = model_enter(v);
        end
        3: begin
          KEY_CLEAR_N = 1'b0; cycles(8);
          model_clear();
        end
        default: begin
          KEY_ENTER_N = 1'b0; KEY_CLEAR_N = 1'b0; cycles(8);
          model_clear();
        end
      endcase
      release_keys();
      check($sformatf("rand%0d.done", ep), 32'(done_cnt - d0), 32'(dn));
      check_state($sformatf("rand%0d", ep));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
